// File: rtl/change_event_arbiter.sv
// Detects value changes on NUM_CH input channels, keeps one pending event per channel,
// and hands them to a single valid/ready consumer in round-robin order.
module change_event_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DW     = 8,
  localparam int CW    = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH*DW-1:0] data_in,
  input  logic                 evt_ready,
  input  logic [NUM_CH-1:0]    overrun_clr,
  output logic                 evt_valid,
  output logic [CW-1:0]        evt_ch,
  output logic [DW-1:0]        evt_data,
  output logic [NUM_CH-1:0]    overrun
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     prev_q   [NUM_CH];
  logic [DW-1:0]     shadow_q [NUM_CH];
  logic [NUM_CH-1:0] pending_q;
  logic [CW-1:0]     ptr_q;

  logic [NUM_CH-1:0] chg;
  logic              found;
  logic [CW-1:0]     sel;
  logic [CW:0]       scan_idx;
  logic [DW-1:0]     sel_data;
  logic              take;
  logic              accept;

  always_comb begin
    chg = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      chg[ch] = (data_in[ch*DW +: DW] != prev_q[ch]);
    end
  end

  // Rotating priority: first pending channel at or after ptr, wrapping past NUM_CH-1.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, ptr_q} + (CW+1)'(i);
      if (scan_idx >= (CW+1)'(NUM_CH)) begin
        scan_idx = scan_idx - (CW+1)'(NUM_CH);
      end
      if (!found && pending_q[scan_idx[CW-1:0]]) begin
        found = 1'b1;
        sel   = scan_idx[CW-1:0];
      end
    end
  end

  assign sel_data = chg[sel] ? data_in[int'(sel)*DW +: DW] : shadow_q[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          take    = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          accept  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh change always re-arms pending, even on the channel being taken this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      overrun   <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        prev_q[ch]   <= '0;
        shadow_q[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        prev_q[ch] <= data_in[ch*DW +: DW];
        if (chg[ch]) begin
          shadow_q[ch]  <= data_in[ch*DW +: DW];
          pending_q[ch] <= 1'b1;
        end else if (take && sel == CW'(ch)) begin
          pending_q[ch] <= 1'b0;
        end
        if (chg[ch] && pending_q[ch] && !(take && sel == CW'(ch))) begin
          overrun[ch] <= 1'b1;
        end else if (overrun_clr[ch]) begin
          overrun[ch] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_data  <= '0;
      ptr_q     <= '0;
    end else if (take) begin
      evt_valid <= 1'b1;
      evt_ch    <= sel;
      evt_data  <= sel_data;
    end else if (accept) begin
      evt_valid <= 1'b0;
      ptr_q     <= (evt_ch == CW'(NUM_CH-1)) ? '0 : evt_ch + CW'(1);
    end
  end

endmodule
